// File: rtl/poca_nlfsr_seq.sv
// rtl/poca_nlfsr_seq.sv - challenge sequencer wrapped around the 32-bit POCA NLFSR
module poca_nlfsr_seq #(
  parameter int RUN_CYCLES = 64,
  parameter int FLIP_W     = 32,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chal_valid,
  output logic              chal_ready,
  input  logic [31:0]       chal_seed,
  input  logic [FLIP_W-1:0] chal_flip,
  input  logic              abort,
  output logic              nlfsr_load,
  output logic [31:0]       nlfsr_seed,
  output logic              nlfsr_start,
  output logic              nlfsr_flip,
  input  logic              nlfsr_out,
  input  logic [31:0]       nlfsr_state,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [CNT_W-1:0]  resp_ones,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(RUN_CYCLES - 1);

  state_t            state, state_next;
  logic [FLIP_W-1:0] flip_sr, flip_sr_next;
  logic [CNT_W-1:0]  run_cnt, run_cnt_next;
  logic [CNT_W-1:0]  ones, ones_next;

  logic              load_next, start_next, flip_next;
  logic [31:0]       seed_next;
  logic              resp_valid_next;
  logic [31:0]       resp_data_next;
  logic [CNT_W-1:0]  resp_ones_next;
  logic              busy_next;

  // Ready is a pure decode of IDLE, held low while reset is asserted.
  assign chal_ready = (state == S_IDLE) && rst_n;

  // Next-state and next-output logic; every NLFSR control is computed one
  // cycle ahead so the registered outputs line up with the state they serve.
  always_comb begin
    state_next      = state;
    flip_sr_next    = flip_sr;
    run_cnt_next    = run_cnt;
    ones_next       = ones;
    load_next       = 1'b0;
    start_next      = 1'b0;
    flip_next       = 1'b0;
    seed_next       = nlfsr_seed;
    resp_valid_next = 1'b0;
    resp_data_next  = resp_data;
    resp_ones_next  = resp_ones;

    case (state)
      S_IDLE: begin
        if (chal_valid && chal_ready) begin
          state_next   = S_LOAD;
          seed_next    = chal_seed;
          flip_sr_next = chal_flip;
          load_next    = 1'b1;
        end
      end
      S_LOAD: begin
        run_cnt_next = '0;
        ones_next    = '0;
        state_next   = S_RUN;
        // First run cycle: start the shift and present schedule bit 0.
        start_next   = 1'b1;
        flip_next    = flip_sr[0];
        flip_sr_next = flip_sr >> 1;
      end
      S_RUN: begin
        // nlfsr_out is bit 0 of the state before this edge's shift.
        ones_next    = ones + {{(CNT_W-1){1'b0}}, nlfsr_out};
        run_cnt_next = run_cnt + CNT_W'(1);
        if (run_cnt == LAST_K) begin
          state_next = S_CAPTURE;
        end else begin
          // The schedule drains to zero, so run cycles past FLIP_W get no flip.
          start_next   = 1'b1;
          flip_next    = flip_sr[0];
          flip_sr_next = flip_sr >> 1;
        end
      end
      S_CAPTURE: begin
        resp_data_next  = nlfsr_state;
        resp_ones_next  = ones;
        resp_valid_next = 1'b1;
        state_next      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_next = S_IDLE;
        end else begin
          resp_valid_next = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort beats chal_valid and resp_ready: drop everything, keep old response.
    if (abort && (state != S_IDLE)) begin
      state_next      = S_IDLE;
      load_next       = 1'b0;
      start_next      = 1'b0;
      flip_next       = 1'b0;
      resp_valid_next = 1'b0;
      resp_data_next  = resp_data;
      resp_ones_next  = resp_ones;
    end

    busy_next = (state_next != S_IDLE);
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      flip_sr     <= '0;
      run_cnt     <= '0;
      ones        <= '0;
      nlfsr_load  <= 1'b0;
      nlfsr_start <= 1'b0;
      nlfsr_flip  <= 1'b0;
      nlfsr_seed  <= '0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_ones   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      flip_sr     <= flip_sr_next;
      run_cnt     <= run_cnt_next;
      ones        <= ones_next;
      nlfsr_load  <= load_next;
      nlfsr_start <= start_next;
      nlfsr_flip  <= flip_next;
      nlfsr_seed  <= seed_next;
      resp_valid  <= resp_valid_next;
      resp_data   <= resp_data_next;
      resp_ones   <= resp_ones_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_poca_nlfsr_seq.sv
// tb/tb_poca_nlfsr_seq.sv - self-checking bench for poca_nlfsr_seq
module tb_poca_nlfsr_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_valid = 1'b0;
  logic        v1 = 1'b0;
  logic [31:0] c_seed = '0;
  logic [31:0] c_flip = '0;
  logic        abort = 1'b0;
  logic        r_ready = 1'b0;
  logic        r1 = 1'b1;

  // Main instance (RUN_CYCLES=64)
  logic        chal_ready, nlfsr_load, nlfsr_start, nlfsr_flip, resp_valid, busy;
  logic [31:0] nlfsr_seed, resp_data;
  logic [7:0]  resp_ones;
  logic [31:0] nst = '0;

  // Short instance (RUN_CYCLES=1)
  logic        chal_ready_1, nlfsr_load_1, nlfsr_start_1, nlfsr_flip_1, resp_valid_1, busy_1;
  logic [31:0] nlfsr_seed_1, resp_data_1;
  logic [7:0]  resp_ones_1;
  logic [31:0] nst_1 = '0;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  poca_nlfsr_seq #(.RUN_CYCLES(64), .FLIP_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .chal_valid(c_valid), .chal_ready(chal_ready),
    .chal_seed(c_seed), .chal_flip(c_flip), .abort(abort),
    .nlfsr_load(nlfsr_load), .nlfsr_seed(nlfsr_seed), .nlfsr_start(nlfsr_start),
    .nlfsr_flip(nlfsr_flip), .nlfsr_out(nst[0]), .nlfsr_state(nst),
    .resp_valid(resp_valid), .resp_ready(r_ready), .resp_data(resp_data),
    .resp_ones(resp_ones), .busy(busy)
  );

  poca_nlfsr_seq #(.RUN_CYCLES(1), .FLIP_W(32), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .chal_valid(v1), .chal_ready(chal_ready_1),
    .chal_seed(c_seed), .chal_flip(c_flip), .abort(abort),
    .nlfsr_load(nlfsr_load_1), .nlfsr_seed(nlfsr_seed_1), .nlfsr_start(nlfsr_start_1),
    .nlfsr_flip(nlfsr_flip_1), .nlfsr_out(nst_1[0]), .nlfsr_state(nst_1),
    .resp_valid(resp_valid_1), .resp_ready(r1), .resp_data(resp_data_1),
    .resp_ones(resp_ones_1), .busy(busy_1)
  );

  // Stand-in POCA NLFSR: right shift, nonlinear feedback into bit 31, flip XORed in.
  function automatic logic [31:0] nl_step(input logic [31:0] s, input logic f);
    logic fb;
    fb = s[0] ^ s[2] ^ (s[5] & s[9]) ^ (s[13] & s[17] & s[21]) ^ f;
    return {fb, s[31:1]};
  endfunction

  // NLFSR peripheral models driven by each sequencer.
  always @(posedge clk) begin
    if (nlfsr_load) nst <= nlfsr_seed;
    else if (nlfsr_start) nst <= nl_step(nst, nlfsr_flip);
    if (nlfsr_load_1) nst_1 <= nlfsr_seed_1;
    else if (nlfsr_start_1) nst_1 <= nl_step(nst_1, nlfsr_flip_1);
  end

  // Expected response: n shifts with flip bit k on shift k (zero past bit 31).
  function automatic logic [39:0] ref_resp(input logic [31:0] seed, input logic [31:0] flip,
                                           input int n);
    logic [31:0] s;
    logic [7:0]  ones;
    logic        f;
    s = seed;
    ones = 8'd0;
    for (int k = 0; k < n; k++) begin
      ones = ones + {7'd0, s[0]};
      f = (k < 32) ? flip[k] : 1'b0;
      s = nl_step(s, f);
    end
    return {ones, s};
  endfunction

  // Observe flip timing per run and load/start overlap on the main instance.
  logic [63:0] flip_hist = '0;
  int          start_cnt = 0;
  int          overlap = 0;
  always @(negedge clk) begin
    if (nlfsr_load) begin
      flip_hist = '0;
      start_cnt = 0;
    end
    if (nlfsr_start) begin
      if (nlfsr_flip && start_cnt < 64) flip_hist[start_cnt] = 1'b1;
      start_cnt++;
    end
    if (nlfsr_load && nlfsr_start) overlap++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Waits for the offer to be taken; returns at the negedge of cycle 1 (LOAD).
  task automatic offer(input logic [31:0] seed, input logic [31:0] flip, input string nm);
    int n;
    @(negedge clk);
    c_seed = seed;
    c_flip = flip;
    c_valid = 1'b1;
    n = 0;
    while (!chal_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " accept"}, chal_ready, 1);
    @(negedge clk);
    c_valid = 1'b0;
  endtask

  task automatic do_chal(input logic [31:0] seed, input logic [31:0] flip,
                         input logic [31:0] exp_d, input logic [7:0] exp_o, input string nm);
    int n;
    offer(seed, flip, nm);
    chk({nm, " load"}, {nlfsr_load, nlfsr_start, nlfsr_seed}, {2'b10, seed});
    n = 1;
    while (!resp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, 67);
    chk({nm, " data"}, resp_data, exp_d);
    chk({nm, " ones"}, resp_ones, exp_o);
    chk({nm, " flips"}, flip_hist, {32'h0, flip});
    chk({nm, " shifts"}, start_cnt, 64);
    chk({nm, " busy/ready"}, {busy, chal_ready}, 2'b10);
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    chk({nm, " done"}, {resp_valid, busy, chal_ready}, 3'b001);
  endtask

  typedef struct {
    logic [31:0] seed;
    logic [31:0] flip;
    logic [31:0] exp_data;
    logic [7:0]  exp_ones;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [39:0] r;
    logic [31:0] hd, sa;
    logic [7:0]  ho;
    int          n;
    bit          seen;

    // Zero seed is a fixed point; the remaining entries come from the model.
    tbl[0] = '{32'h0, 32'h0, 32'h0, 8'd0};
    tbl[1].seed = 32'h0;
    tbl[1].flip = 32'h1;
    tbl[2].seed = 32'hFFFF_FFFF;
    tbl[2].flip = 32'hFFFF_FFFF;
    for (int i = 3; i < 6; i++) begin
      tbl[i].seed = $urandom;
      tbl[i].flip = $urandom;
    end
    for (int i = 1; i < 6; i++) begin
      r = ref_resp(tbl[i].seed, tbl[i].flip, 64);
      tbl[i].exp_data = r[31:0];
      tbl[i].exp_ones = r[39:32];
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset outs", {resp_valid, nlfsr_load, nlfsr_start, nlfsr_flip, busy, resp_data, resp_ones, nlfsr_seed},
        '0);
    rst_n = 1'b1;
    #1;
    chk("ready after reset", chal_ready, 1);

    // Table-driven challenges
    for (int i = 0; i < 6; i++) begin
      do_chal(tbl[i].seed, tbl[i].flip, tbl[i].exp_data, tbl[i].exp_ones, $sformatf("vec%0d", i));
    end

    // RUN_CYCLES=1, seed 1: single shift gives 0x8000_0000, one 1 seen
    @(negedge clk);
    c_seed = 32'h1;
    c_flip = 32'h0;
    v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0;
    n = 1;
    while (!resp_valid_1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("run1 latency", n, 4);
    chk("run1 data", resp_data_1, 32'h8000_0000);
    chk("run1 ones", resp_ones_1, 8'd1);

    // Backpressure: response held, new offers ignored
    sa = $urandom;
    offer(sa, 32'h0000_00F0, "bp");
    c_valid = 1'b1;
    c_seed = ~sa;
    n = 1;
    while (!resp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    r = ref_resp(sa, 32'h0000_00F0, 64);
    chk("bp data", {resp_ones, resp_data}, r);
    hd = resp_data;
    ho = resp_ones;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d", i), {resp_valid, chal_ready, resp_ones, resp_data}, {2'b10, ho, hd});
    end
    c_valid = 1'b0;
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    chk("bp done", {resp_valid, busy, chal_ready}, 3'b001);
    @(negedge clk);
    chk("bp no restart", {busy, nlfsr_load}, 2'b00);

    // Abort at RUN k=5 (cycle 7)
    offer(32'hDEAD_BEEF, 32'hFFFF_FFFF, "abort");
    repeat (6) @(negedge clk);
    chk("abort pre", nlfsr_start, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort post", {nlfsr_start, nlfsr_flip, nlfsr_load, busy, chal_ready}, 5'b00001);
    chk("abort keeps resp", {resp_ones, resp_data}, {ho, hd});
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("abort no resp", seen, 0);

    // Asynchronous reset mid-RUN, then a normal challenge
    offer(32'h1234_5678, 32'h5555_5555, "rst");
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset", {resp_valid, nlfsr_load, nlfsr_start, nlfsr_flip, busy, resp_data, resp_ones, nlfsr_seed},
        '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready after rst", chal_ready, 1);
    r = ref_resp(32'hCAFE_F00D, 32'h8000_0001, 64);
    do_chal(32'hCAFE_F00D, 32'h8000_0001, r[31:0], r[39:32], "post-rst");

    chk("load/start overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
